// File: rtl/spram_pkg.sv
// spram_pkg: shared types and helpers for the banked single-port RAM.
//   spram_st_t  - sequencer state (CLEAR = post-reset zero-fill, RUN = normal access)
//   RDW_HOLD / RDW_SHOW - read-during-write result selection for vo
//   lane_merge  - byte-lane merge of a new word over an old word
package spram_pkg;

    typedef enum logic {CLEAR, RUN} spram_st_t;

    localparam int RDW_HOLD = 0;
    localparam int RDW_SHOW = 1;

    // Widest word lane_merge handles; callers zero-extend and truncate.
    localparam int MAX_DSZ = 1024;

    // Lane n of the result comes from nw when mask[n] is set, else from old.
    function automatic logic [MAX_DSZ-1:0] lane_merge(
        input logic [MAX_DSZ-1:0]   old,
        input logic [MAX_DSZ-1:0]   nw,
        input logic [MAX_DSZ/8-1:0] mask
    );
        logic [MAX_DSZ-1:0] r;
        r = old;
        for (int n = 0; n < MAX_DSZ/8; n++)
            if (mask[n]) r[8*n +: 8] = nw[8*n +: 8];
        return r;
    endfunction

endpackage

// File: rtl/spram_bank.sv
// spram_bank: one byte-enabled single-port bank, depth 2**RSZ, 1-cycle
// registered read.
//   clk  in   clock
//   en   in   bank enable for this cycle
//   we   in   1 = write, 0 = read
//   row  in   row address inside the bank
//   wd   in   write data
//   wm   in   byte-lane write mask
//   rd   out  registered read data; on a write it holds (RDW_HOLD) or takes
//             the merged word (RDW_SHOW)
module spram_bank
    import spram_pkg::*;
#(
    parameter int DSZ = 32,
    parameter int RSZ = 13,
    parameter int RDW = 0
) (
    input  logic                            clk,
    input  logic                            en,
    input  logic                            we,
    input  logic [((RSZ > 0) ? RSZ : 1)-1:0] row,
    input  logic [DSZ-1:0]                  wd,
    input  logic [DSZ/8-1:0]                wm,
    output logic [DSZ-1:0]                  rd
);

    localparam int NL = DSZ / 8;

    logic [DSZ-1:0] mem [0:(2**RSZ)-1];

    // No reset on the array or rd: the top-level sequencer zero-fills the
    // array, and rd is only observed after an access has loaded it.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int n = 0; n < NL; n++)
                    if (wm[n]) mem[row][8*n +: 8] <= wd[8*n +: 8];
                if (RDW == RDW_SHOW)
                    rd <= DSZ'(lane_merge(MAX_DSZ'(mem[row]), MAX_DSZ'(wd),
                                          (MAX_DSZ/8)'(wm)));
            end else begin
                rd <= mem[row];
            end
        end
    end

endmodule

// File: rtl/spram_banked.sv
// spram_banked: parametrised banked single-port RAM slave with req/rdy
// handshake, byte-lane writes, registered read-valid and a post-reset
// zero-fill sequencer.
//   clk   in   clock
//   rst   in   asynchronous active-high reset
//   req   in   access request, taken when req & rdy
//   we    in   1 = write, 0 = read
//   ai    in   word address; bank = MSBs, row = low bits
//   vi    in   write data
//   bmsk  in   byte-lane write enable
//   rdy   out  request can be accepted this cycle
//   vo    out  read data (registered in the banks)
//   vld   out  vo holds the result of the read accepted last cycle
//   busy  out  zero-fill in progress
module spram_banked
    import spram_pkg::*;
#(
    parameter int DSZ   = 32,
    parameter int ASZ   = 15,
    parameter int NBANK = 4,
    parameter int RDW   = 0,
    parameter int CLR   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [ASZ-1:0]   ai,
    input  logic [DSZ-1:0]   vi,
    input  logic [DSZ/8-1:0] bmsk,
    output logic             rdy,
    output logic [DSZ-1:0]   vo,
    output logic             vld,
    output logic             busy
);

    localparam int NL  = DSZ / 8;
    localparam int BW  = (NBANK > 1) ? $clog2(NBANK) : 0;  // bank-select bits
    localparam int RSZ = ASZ - BW;                          // row bits
    localparam int RW  = (RSZ > 0) ? RSZ : 1;
    localparam int SW  = (BW > 0) ? BW : 1;
    localparam logic [RW-1:0] CNT_LAST = RW'((2**RSZ) - 1);
    localparam logic SHOW = (RDW == RDW_SHOW);

    // Elaboration-time parameter checks.
    if (DSZ % 8 != 0 || DSZ < 8) begin : g_err_dsz
        $error("spram_banked: DSZ must be a positive multiple of 8");
    end
    if (NBANK < 1 || (NBANK & (NBANK - 1)) != 0) begin : g_err_nbank
        $error("spram_banked: NBANK must be a power of 2");
    end
    if (NBANK > 2**ASZ) begin : g_err_depth
        $error("spram_banked: NBANK exceeds 2**ASZ");
    end

    // ------------------------------------------------------------------
    // Sequencer: CLEAR zero-fills row cnt of every bank each cycle, then
    // RUN forever. busy/rdy are registered and swap on the same edge.
    // ------------------------------------------------------------------
    spram_st_t     st;
    logic [RW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= (CLR != 0) ? CLEAR : RUN;
            cnt  <= '0;
            busy <= (CLR != 0);
            rdy  <= 1'b0;
        end else begin
            case (st)
                CLEAR: begin
                    if (cnt == CNT_LAST) begin
                        st   <= RUN;
                        busy <= 1'b0;
                        rdy  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                    rdy  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bank decode. rdy is only ever 1 in RUN, so acc never overlaps CLEAR.
    // ------------------------------------------------------------------
    logic          clr;
    logic          acc;
    logic [SW-1:0] bsel;
    logic [RW-1:0] arow;

    assign clr = (st == CLEAR);
    assign acc = req & rdy;

    if (BW > 0) begin : g_bsel
        assign bsel = ai[ASZ-1 -: SW];
    end else begin : g_bsel0
        assign bsel = '0;
    end

    if (RSZ > 0) begin : g_row
        assign arow = ai[RW-1:0];
    end else begin : g_row0
        assign arow = '0;
    end

    // Shared bank buses; only the enable is per bank. During CLEAR every
    // bank is enabled and writes zero to all lanes at row cnt.
    logic                        b_we;
    logic [RW-1:0]               b_row;
    logic [DSZ-1:0]              b_wd;
    logic [NL-1:0]               b_wm;
    logic [NBANK-1:0]            b_en;
    logic [NBANK-1:0][DSZ-1:0]   b_rd;

    assign b_we  = clr | we;
    assign b_row = clr ? cnt : arow;
    assign b_wd  = clr ? '0 : vi;
    assign b_wm  = clr ? '1 : bmsk;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign b_en[b] = clr | (acc & (bsel == SW'(b)));

        spram_bank #(
            .DSZ (DSZ),
            .RSZ (RSZ),
            .RDW (RDW)
        ) u_bank (
            .clk (clk),
            .en  (b_en[b]),
            .we  (b_we),
            .row (b_row),
            .wd  (b_wd),
            .wm  (b_wm),
            .rd  (b_rd[b])
        );
    end

    // ------------------------------------------------------------------
    // Output path. upd_q marks a cycle where the selected bank's rd holds
    // a fresh result (a read, or a write under RDW_SHOW); otherwise vo
    // replays its previous value from vo_hold.
    // ------------------------------------------------------------------
    logic           upd_q;
    logic [SW-1:0]  bsel_q;
    logic [DSZ-1:0] vo_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= 1'b0;
            upd_q   <= 1'b0;
            bsel_q  <= '0;
            vo_hold <= '0;
        end else begin
            vld     <= acc & ~we;
            upd_q   <= acc & (~we | SHOW);
            vo_hold <= vo;
            if (acc) bsel_q <= bsel;
        end
    end

    assign vo = upd_q ? b_rd[bsel_q] : vo_hold;

endmodule

// File: tb/tb_spram_banked.sv
// Directed bench for spram_banked: two instances sharing stimulus, one with
// RDW hold and one with RDW show, so read-during-write results on vo can be
// compared side by side. Table-driven vectors cover the run-time accesses;
// reset, fill length and mid-fill reset are hand-written sequences.
module tb_spram_banked;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [14:0] ai;
    logic [31:0] vi;
    logic [3:0]  bmsk;

    logic        rdy0, vld0, busy0, rdy1, vld1, busy1;
    logic [31:0] vo0, vo1;

    always #5 clk = ~clk;

    spram_banked #(.DSZ(32), .ASZ(15), .NBANK(4), .RDW(0), .CLR(1)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .ai(ai), .vi(vi), .bmsk(bmsk),
        .rdy(rdy0), .vo(vo0), .vld(vld0), .busy(busy0)
    );

    spram_banked #(.DSZ(32), .ASZ(15), .NBANK(4), .RDW(1), .CLR(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .ai(ai), .vi(vi), .bmsk(bmsk),
        .rdy(rdy1), .vo(vo1), .vld(vld1), .busy(busy1)
    );

    typedef struct {
        string       nm;
        logic        req;
        logic        we;
        logic [14:0] ai;
        logic [31:0] vi;
        logic [3:0]  bmsk;
        logic        evld;
        logic [31:0] evo0;   // expected vo, RDW hold instance
        logic [31:0] evo1;   // expected vo, RDW show instance
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic r, input logic w, input logic [14:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic ev,
                       input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.nm = nm; v.req = r; v.we = w; v.ai = a; v.vi = d; v.bmsk = m;
        v.evld = ev; v.evo0 = e0; v.evo1 = e1;
        tbl.push_back(v);
    endtask

    task automatic wr(input string nm, input logic [14:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [31:0] e0, input logic [31:0] e1);
        add(nm, 1'b1, 1'b1, a, d, m, 1'b0, e0, e1);
    endtask

    task automatic rd(input string nm, input logic [14:0] a, input logic [31:0] e);
        add(nm, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, e, e);
    endtask

    task automatic idle(input string nm, input logic [31:0] e0, input logic [31:0] e1);
        add(nm, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0, 1'b0, e0, e1);
    endtask

    // Counts edges until rdy0 rises; bounded so a stuck fill still ends.
    task automatic wait_rdy(output int cyc, output logic pre_busy);
        cyc = 0;
        pre_busy = 1'b0;
        while (!rdy0 && cyc < 9000) begin
            pre_busy = busy0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    function automatic logic [14:0] bank_addr(input int k);
        if (k < 15) return 15'(31 + (1 << k));
        return 15'(32767 - (k - 15));
    endfunction

    function automatic logic [31:0] bank_data(input int k);
        return 32'h1000_0000 | (32'(k) << 16) | 32'(bank_addr(k));
    endfunction

    int   cyc;
    logic pre_busy;

    initial begin
        // ---------------- vector table ----------------
        rd  ("rd_7fff_cleared", 15'h7fff, 32'h0);
        wr  ("wr0_full",  15'h0, 32'hDEADBEEF, 4'hF, 32'h0, 32'hDEADBEEF);
        wr  ("wr0_lo2",   15'h0, 32'h12345678, 4'h3, 32'h0, 32'hDEAD5678);
        rd  ("rd0_merge", 15'h0, 32'hDEAD5678);
        wr  ("wr0_nomask",15'h0, 32'hFFFFFFFF, 4'h0, 32'hDEAD5678, 32'hDEAD5678);
        rd  ("rd0_keep",  15'h0, 32'hDEAD5678);
        wr  ("rdw_lane0", 15'h1, 32'hFFFFFFFF, 4'h1, 32'hDEAD5678, 32'h000000FF);
        idle("idle_hold", 32'hDEAD5678, 32'h000000FF);
        rd  ("rd1",       15'h1, 32'h000000FF);
        wr  ("b2b_wr",    15'h100, 32'hA5A5A5A5, 4'hF, 32'h000000FF, 32'hA5A5A5A5);
        rd  ("b2b_rd",    15'h100, 32'hA5A5A5A5);
        idle("b2b_idle",  32'hA5A5A5A5, 32'hA5A5A5A5);
        for (int k = 0; k < 30; k++)
            wr($sformatf("edge_wr%0d", k), bank_addr(k), bank_data(k), 4'hF,
               32'hA5A5A5A5, bank_data(k));
        for (int k = 0; k < 30; k++)
            rd($sformatf("edge_rd%0d", k), bank_addr(k), bank_data(k));

        // ---------------- reset state ----------------
        rst = 1'b1; req = 1'b0; we = 1'b0; ai = '0; vi = '0; bmsk = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy",  32'(rdy0),  32'h0);
        chk("rst_vld",  32'(vld0),  32'h0);
        chk("rst_vo",   vo0,        32'h0);
        chk("rst_busy", 32'(busy0), 32'h1);

        // ---------------- fill length ----------------
        rst = 1'b0;
        wait_rdy(cyc, pre_busy);
        chk("fill_cycles",   32'(cyc),      32'd8192);
        chk("fill_pre_busy", 32'(pre_busy), 32'h1);
        chk("fill_busy_low", 32'(busy0),    32'h0);
        chk("fill_rdy1",     32'(rdy1),     32'h1);

        // ---------------- table run ----------------
        foreach (tbl[i]) begin
            req = tbl[i].req; we = tbl[i].we; ai = tbl[i].ai;
            vi = tbl[i].vi; bmsk = tbl[i].bmsk;
            @(posedge clk); #1;
            chk({tbl[i].nm, " vld0"}, 32'(vld0), 32'(tbl[i].evld));
            chk({tbl[i].nm, " vld1"}, 32'(vld1), 32'(tbl[i].evld));
            chk({tbl[i].nm, " vo0"},  vo0, tbl[i].evo0);
            chk({tbl[i].nm, " vo1"},  vo1, tbl[i].evo1);
        end
        req = 1'b0;

        // ---------------- reset mid-fill, req held during fill ----------------
        rst = 1'b1;
        #1;
        chk("rst2_vo",   vo0,        32'h0);
        chk("rst2_busy", 32'(busy0), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        req = 1'b1; we = 1'b1; ai = 15'h0; vi = 32'hFFFFFFFF; bmsk = 4'hF;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy0), 32'h1);
        chk("mid_rdy",  32'(rdy0),  32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_rdy(cyc, pre_busy);
        req = 1'b0;
        chk("refill_cycles", 32'(cyc), 32'd8192);

        req = 1'b1; we = 1'b0; ai = 15'h0;
        @(posedge clk); #1;
        chk("refill_rd0 vld", 32'(vld0), 32'h1);
        chk("refill_rd0 vo0", vo0, 32'h0);
        chk("refill_rd0 vo1", vo1, 32'h0);
        ai = 15'h7fff;
        @(posedge clk); #1;
        chk("refill_rd7fff vld", 32'(vld0), 32'h1);
        chk("refill_rd7fff vo0", vo0, 32'h0);
        req = 1'b0;
        @(posedge clk); #1;
        chk("refill_idle vld", 32'(vld0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
